// File: rtl/pipe_ctrl.sv
// pipe_ctrl: RV32I pipeline stall/flush controller with deferred PC redirect and debug counters.
module pipe_ctrl #(
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             jump_req,
    input  logic [31:0]      jump_target,
    output logic [5:0]       stall_state,
    output logic             jump_flag,
    output logic             pc_redirect,
    output logic [31:0]      pc_redirect_addr,
    output logic             if_discard,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic IDLE = 1'b0;
    localparam logic PEND = 1'b1;
    localparam int   RW   = $clog2(WDOG_LIMIT + 1);

    logic             state_q, state_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic [RW-1:0]    run_q, run_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, stall_q, stall_d, flush_q, flush_d;
    logic             acc;

    always_comb begin
        stall_state = rst ? 6'b000000 : !rdy ? 6'b111111 : stallreq_mem ? 6'b011111 :
                      stallreq_ex ? 6'b001111 : stallreq_id ? 6'b000111 :
                      stallreq_if ? 6'b000011 : 6'b000000;
        acc = !rst & jump_req & rdy & !stallreq_mem & !stallreq_ex;
        jump_flag = acc;
        // A jump accepted while pending supersedes the stored target immediately
        pc_redirect = (state_q == IDLE) ? acc & !stallreq_if : !rst & rdy & !stallreq_if;
        pc_redirect_addr = (state_q == IDLE || acc) ? jump_target : pend_addr_q;
        if_discard = (state_q == PEND) ? !rst : acc & stallreq_if;
        state_d = !pc_redirect & (acc | state_q);
        pend_addr_d = acc ? jump_target : pend_addr_q;
        run_d = (stall_state == 6'b0) ? '0 : (run_q == RW'(WDOG_LIMIT)) ? run_q : run_q + 1'b1;
        timeout_d = timeout_q | (run_d == RW'(WDOG_LIMIT));
        cyc_d = &cyc_q ? cyc_q : cyc_q + 1'b1;
        stall_d = (stall_state[0] & ~&stall_q) ? stall_q + 1'b1 : stall_q;
        flush_d = (acc & ~&flush_q) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
            cyc_q       <= '0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
            cyc_q       <= cyc_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

    assign stall_timeout = timeout_q;
    assign cyc_cnt       = cyc_q;
    assign stall_cnt     = stall_q;
    assign flush_cnt     = flush_q;
endmodule
